// File: rtl/mbm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mbm_pkg
// Brief   : Shared types, geometry constants and helpers for the multi-bank
//           memory scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package mbm_pkg;

   // Default scheduler geometry; the select/index widths follow from it.
   localparam int N_REQ_DEF   = 4;
   localparam int N_BANKS_DEF = 4;
   localparam int BANK_SEL_W  = $clog2(N_BANKS_DEF);
   localparam int REQ_IDX_W   = $clog2(N_REQ_DEF);

   // One outstanding read per bank: valid flag plus the requester that owns it.
   typedef struct packed {
      logic                 valid;
      logic [REQ_IDX_W-1:0] owner;
   } rd_pend_t;

   // One-hot to binary encoder; OR-accumulates so it stays a pure encoder.
   function automatic logic [REQ_IDX_W-1:0] onehot_to_idx(input logic [N_REQ_DEF-1:0] oh);
      logic [REQ_IDX_W-1:0] idx;
      idx = '0;
      for (int k = 0; k < N_REQ_DEF; k++) begin
         if (oh[k]) idx = idx | REQ_IDX_W'(k);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/arbiter.sv
`default_nettype none
// ============================================================================
// Module  : arbiter
// Brief   : Round-robin arbiter with combinational one-hot grant. The priority
//           pointer moves to the requester after the most recent grantee.
// Revision: 1.0 - initial release
// ============================================================================
module arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_gnt
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_idx;
   logic          w_any;

   // Scan requesters starting at the pointer; first active one wins.
   always_comb begin : c_scan
      int            j;
      logic [IW-1:0] w_j;
      o_gnt = '0;
      w_idx = '0;
      w_any = 1'b0;
      j     = 0;
      w_j   = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(r_ptr) + k;
         if (j >= N) j = j - N;
         w_j = IW'(j);
         if (!w_any && i_req[w_j]) begin
            o_gnt[w_j] = 1'b1;
            w_idx      = w_j;
            w_any      = 1'b1;
         end
      end
   end

   // Advance the pointer past the grantee whenever a grant is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_any) begin
         r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : bank_scheduler
// Brief   : Routes requester ports onto low-order-interleaved single-port
//           SRAM banks, one round-robin arbiter per bank, returns read data
//           one cycle after the grant and counts conflict cycles.
// Revision: 1.0 - initial release
// ============================================================================
module bank_scheduler
   import mbm_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int N_BANKS = N_BANKS_DEF,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [N_REQ-1:0]                      req_valid,
   output logic [N_REQ-1:0]                      req_ready,
   input  logic [N_REQ-1:0]                      req_we,
   input  logic [N_REQ*ADDR_W-1:0]               req_addr,
   input  logic [N_REQ*DATA_W-1:0]               req_wdata,
   output logic [N_REQ-1:0]                      rsp_valid,
   output logic [N_REQ*DATA_W-1:0]               rsp_rdata,
   output logic [N_BANKS-1:0]                    bank_en,
   output logic [N_BANKS-1:0]                    bank_we,
   output logic [N_BANKS*(ADDR_W-BANK_SEL_W)-1:0] bank_addr,
   output logic [N_BANKS*DATA_W-1:0]             bank_wdata,
   input  logic [N_BANKS*DATA_W-1:0]             bank_rdata,
   output logic [CNT_W-1:0]                      conflict_cnt
);

   localparam int BS  = BANK_SEL_W;
   localparam int IAW = ADDR_W - BS;

   // Flattened per-bank grant vectors and pending-read records.
   logic [N_BANKS*N_REQ-1:0]     w_gnt_all;
   logic [N_BANKS-1:0]           w_pend_v;
   logic [N_BANKS*REQ_IDX_W-1:0] w_pend_own;
   logic [N_REQ-1:0]             w_rd_grant;
   logic [N_REQ-1:0]             r_rsp_valid;
   logic [CNT_W-1:0]             r_cnt;
   logic                         w_conflict;

   genvar b;
   generate
      for (b = 0; b < N_BANKS; b++) begin : g_bank
         logic [N_REQ-1:0]  w_req;
         logic [N_REQ-1:0]  w_gnt_b;
         logic              w_we;
         logic [IAW-1:0]    w_addr;
         logic [DATA_W-1:0] w_wdata;
         rd_pend_t          r_pend;

         // Requesters whose low address bits select this bank.
         always_comb begin
            w_req = '0;
            for (int i = 0; i < N_REQ; i++) begin
               w_req[i] = req_valid[i] & (req_addr[i*ADDR_W +: BS] == BS'(b));
            end
         end

         arbiter #(
            .N (N_REQ)
         ) u_arb (
            .clk   (clk),
            .rst   (rst),
            .i_req (w_req),
            .o_gnt (w_gnt_b)
         );

         // AND-OR mux of the granted requester; all zero when nobody is granted.
         always_comb begin
            w_we    = 1'b0;
            w_addr  = '0;
            w_wdata = '0;
            for (int i = 0; i < N_REQ; i++) begin
               if (w_gnt_b[i]) begin
                  w_we    = w_we | req_we[i];
                  w_addr  = w_addr | req_addr[i*ADDR_W + BS +: IAW];
                  w_wdata = w_wdata | req_wdata[i*DATA_W +: DATA_W];
               end
            end
         end

         assign w_gnt_all[b*N_REQ +: N_REQ] = w_gnt_b;
         assign bank_en[b]                  = |w_gnt_b;
         assign bank_we[b]                  = w_we;
         assign bank_addr[b*IAW +: IAW]     = w_addr;
         assign bank_wdata[b*DATA_W +: DATA_W] = w_wdata;

         // Remember which requester owns the read issued this cycle.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_pend <= '0;
            end else begin
               r_pend.valid <= bank_en[b] & ~w_we;
               r_pend.owner <= onehot_to_idx(w_gnt_b);
            end
         end

         assign w_pend_v[b]                         = r_pend.valid;
         assign w_pend_own[b*REQ_IDX_W +: REQ_IDX_W] = r_pend.owner;
      end
   endgenerate

   // Ready and read-grant per requester: OR of its grant across all banks.
   always_comb begin
      req_ready  = '0;
      w_rd_grant = '0;
      for (int bb = 0; bb < N_BANKS; bb++) begin
         for (int i = 0; i < N_REQ; i++) begin
            req_ready[i]  = req_ready[i] | w_gnt_all[bb*N_REQ + i];
            w_rd_grant[i] = w_rd_grant[i] | (w_gnt_all[bb*N_REQ + i] & ~bank_we[bb]);
         end
      end
   end

   // Response valid lands exactly one cycle after a read handshake.
   always_ff @(posedge clk) begin
      if (rst) r_rsp_valid <= '0;
      else     r_rsp_valid <= w_rd_grant;
   end

   assign rsp_valid = r_rsp_valid;

   // Route each bank's read data to the requester recorded as its owner.
   always_comb begin
      rsp_rdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         for (int bb = 0; bb < N_BANKS; bb++) begin
            if (w_pend_v[bb] && (w_pend_own[bb*REQ_IDX_W +: REQ_IDX_W] == REQ_IDX_W'(i))) begin
               rsp_rdata[i*DATA_W +: DATA_W] = rsp_rdata[i*DATA_W +: DATA_W]
                                             | bank_rdata[bb*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign w_conflict = |(req_valid & ~req_ready);

   // Saturating count of cycles where some requester was left waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_conflict && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire
